display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 108 ++++++++++
 tb/tb_display_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: blank/on/off slot timing with a
// double-buffered digit load. Define SCAN_LEADING_ZERO_BLANK_EN to darken a leading zero.
module display_scan_ctrl #(
    parameter int TICK_DIV     = 4000,
    parameter int BLANK_CYCLES = 400
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] digits_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [2:0]  brightness,
    output logic [3:0]  seg_code,
    output logic        seg_blank,
    output logic [3:0]  gnd_n,
    output logic        frame_done
);

    localparam int STEP = (TICK_DIV - BLANK_CYCLES) / 8;
    localparam int CW   = $clog2(TICK_DIV);

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

    logic [CW-1:0] r_slot_cnt;
    logic [1:0]    r_digit_idx;
    logic [2:0]    r_lvl;
    logic [15:0]   r_active;
    logic [15:0]   r_shadow;
    logic          r_pending;
    logic [3:0]    r_gnd_n;
    logic [3:0]    r_seg_code;
    logic          r_seg_blank;
    logic          r_frame_done;

    logic          w_slot_last;
    logic          w_boundary;
    logic          w_accept;
    logic [2:0]    w_lvl;
    logic          w_lz_dark;
    logic [31:0]   w_on_end;
    phase_t        w_phase;
    logic          w_lit;
    logic [3:0]    w_gnd_n_nxt;

    assign w_slot_last = (r_slot_cnt == CW'(TICK_DIV - 1));
    assign w_boundary  = w_slot_last && (r_digit_idx == 2'd3);
    assign w_accept    = load_valid && !r_pending;
    // Level is latched at slot start; the live input is used on that first cycle itself.
    assign w_lvl       = (r_slot_cnt == '0) ? brightness : r_lvl;

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    assign w_lz_dark = (r_digit_idx == 2'd0) && (r_active[3:0] == 4'd0);
`else
    assign w_lz_dark = 1'b0;
`endif

    always_comb begin
        w_phase  = PH_OFF;
        w_on_end = 32'(BLANK_CYCLES) + (32'(w_lvl) + 32'd1) * 32'(STEP);
        if (32'(r_slot_cnt) < 32'(BLANK_CYCLES))
            w_phase = PH_BLANK;
        else if (32'(r_slot_cnt) < w_on_end)
            w_phase = PH_ON;
        w_lit       = (w_phase == PH_ON) && !w_lz_dark;
        w_gnd_n_nxt = w_lit ? ~(4'b0001 << r_digit_idx) : 4'b1111;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_slot_cnt   <= '0;
            r_digit_idx  <= 2'd0;
            r_lvl        <= 3'd0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_gnd_n      <= 4'b1111;
            r_seg_code   <= 4'd0;
            r_seg_blank  <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + CW'(1);
            if (w_slot_last)
                r_digit_idx <= r_digit_idx + 2'd1;
            if (r_slot_cnt == '0)
                r_lvl <= brightness;
            if (w_accept)
                r_shadow <= digits_in;
            // Accept and copy are exclusive: an accept needs pending low, a copy needs it high.
            if (w_boundary && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
            r_gnd_n      <= w_gnd_n_nxt;
            r_seg_code   <= r_active[{r_digit_idx, 2'b00} +: 4];
            r_seg_blank  <= !w_lit;
            r_frame_done <= w_boundary;
        end
    end

    assign load_ready = !r_pending;
    assign seg_code   = r_seg_code;
    assign seg_blank  = r_seg_blank;
    assign gnd_n      = r_gnd_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (TICK_DIV=20, BLANK_CYCLES=4): stimulus queues
// expected lit runs per frame; a monitor measures each gnd_n low run and compares.
module tb_display_scan_ctrl;

    localparam int TD = 20;
    localparam int BC = 4;
    localparam int LIT_MAX = TD - BC;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] digits_in;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  brightness;
    logic [3:0]  seg_code;
    logic        seg_blank;
    logic [3:0]  gnd_n;
    logic        frame_done;

    display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .CLK(CLK), .RST(RST), .digits_in(digits_in), .load_valid(load_valid),
        .load_ready(load_ready), .brightness(brightness), .seg_code(seg_code),
        .seg_blank(seg_blank), .gnd_n(gnd_n), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct { int digit; int code; int len; int gap; } run_t;
    run_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    int gap_acc = 0;

    function automatic void chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Queue the lit runs one frame should produce; gap = dark cycles before each run.
    task automatic exp_frame(input logic [15:0] act, input int l0, input int l1,
                             input int l2, input int l3);
        int lens [4];
        lens = '{l0, l1, l2, l3};
        for (int k = 0; k < 4; k++) begin
            run_t r;
            if (LZB && k == 0 && act[3:0] == 4'd0) begin
                gap_acc += TD;
            end else begin
                r.digit = k;
                r.code  = int'(act[4*k +: 4]);
                r.len   = lens[k];
                r.gap   = gap_acc + BC;
                exp_q.push_back(r);
                gap_acc = LIT_MAX - lens[k];
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sync_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge CLK);
            got = frame_done;
        end
        chk("frame_done_seen", int'(frame_done), 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnd_n", int'(gnd_n), 15);
        chk("rst_seg_code", int'(seg_code), 0);
        chk("rst_seg_blank", int'(seg_blank), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_load_ready", int'(load_ready), 1);
    endtask

    // Monitor state
    bit         in_run, run_chk, r_bad, gap_bad, fd_seen;
    int         gap_cnt, r_len, r_gap, fd_cnt;
    logic [3:0] r_gnd, r_code;

    task automatic end_run();
        run_t e;
        int d;
        chk("expected_run_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = -1;
            for (int k = 0; k < 4; k++) if (!r_gnd[k]) d = k;
            chk("run_digit", d, e.digit);
            chk("run_code", int'(r_code), e.code);
            chk("run_len", r_len, e.len);
            chk("run_gap", r_gap, e.gap);
            chk("run_clean", int'(r_bad), 0);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            in_run = 1'b0; gap_cnt = 0; gap_bad = 1'b0; fd_seen = 1'b0; fd_cnt = 0;
        end else begin
            if (frame_done) begin
                if (fd_seen) chk("frame_period", fd_cnt, 4 * TD);
                fd_seen = 1'b1;
                fd_cnt  = 1;
            end else begin
                fd_cnt++;
            end
            if (gnd_n == 4'b1111) begin
                if (in_run) begin
                    in_run = 1'b0;
                    if (run_chk) end_run();
                    gap_cnt = 1;
                end else begin
                    gap_cnt++;
                end
                if (!seg_blank) gap_bad = 1'b1;
            end else begin
                if (!in_run) begin
                    in_run = 1'b1; run_chk = mon_en; r_gnd = gnd_n; r_code = seg_code;
                    r_len = 1; r_gap = gap_cnt; r_bad = gap_bad; gap_bad = 1'b0;
                end else begin
                    r_len++;
                end
                if ($countones(~gnd_n) != 1 || seg_blank || gnd_n != r_gnd || seg_code != r_code)
                    r_bad = 1'b1;
            end
        end
    end

    initial begin
        RST = 1'b1; load_valid = 1'b0; digits_in = 16'h0000; brightness = 3'd7;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs();
        wait_cyc(1);
        RST = 1'b0;

        // Full brightness: 4 blank + 16 lit per slot, digits 0..3
        sync_frame();
        mon_en = 1'b1; gap_acc = 0;
        exp_frame(16'h0000, 16, 16, 16, 16);

        // Brightness changes mid-slot only take effect from the next slot
        sync_frame();
        exp_frame(16'h0000, 16, 2, 2, 8);
        wait_cyc(10); brightness = 3'd0;
        wait_cyc(40); brightness = 3'd3;

        // Mid-frame load, then a second offer while pending is ignored
        sync_frame();
        exp_frame(16'h0000, 8, 8, 8, 8);
        wait_cyc(30); load_valid = 1'b1; digits_in = 16'h1234;
        @(negedge CLK); chk("ready_before_load", int'(load_ready), 1);
        wait_cyc(1); load_valid = 1'b0;
        @(negedge CLK); chk("ready_after_load", int'(load_ready), 0);
        wait_cyc(3); load_valid = 1'b1; digits_in = 16'hABCD;
        @(negedge CLK); chk("ready_while_pending", int'(load_ready), 0);
        wait_cyc(1); load_valid = 1'b0; digits_in = 16'h0000;

        // New digits from this frame; then a load exactly on the boundary cycle
        sync_frame();
        chk("ready_after_copy", int'(load_ready), 1);
        exp_frame(16'h1234, 8, 8, 8, 8);
        wait_cyc(4 * TD - 1); load_valid = 1'b1; digits_in = 16'h5900;
        @(negedge CLK);
        chk("ready_on_boundary", int'(load_ready), 1);
        chk("fd_low_on_boundary", int'(frame_done), 0);
        wait_cyc(1); load_valid = 1'b0; digits_in = 16'h0000;
        @(negedge CLK);
        chk("fd_after_boundary", int'(frame_done), 1);
        chk("ready_after_boundary_load", int'(load_ready), 0);
        exp_frame(16'h1234, 8, 8, 8, 8);

        // Boundary load shows up one frame later
        sync_frame();
        chk("ready_after_second_copy", int'(load_ready), 1);
        exp_frame(16'h5900, 8, 8, 8, 8);

        // Reset during digit 2's ON phase
        sync_frame();
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        wait_cyc(2 * TD + 7);
        @(negedge CLK); chk("digit2_on_before_rst", int'(gnd_n), 4'b1011);
        wait_cyc(1); RST = 1'b1;
        wait_cyc(1); RST = 1'b0;
        @(negedge CLK);
        chk_reset_outputs();
        mon_en = 1'b1; gap_acc = 1;
        exp_frame(16'h0000, 8, 8, 8, 8);
        sync_frame();
        wait_cyc(5);
        @(negedge CLK); chk("queue_drained_after_rst", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
